// File: rtl/axis_frame_meter.sv
// ---------------------------------------------------------------------------
// axis_frame_meter
//   AXI-Stream pass-through stage with a 2-entry skid buffer that meters each
//   frame's byte length from tkeep, flags malformed frames and keeps running
//   frame/byte statistics. Metering happens at input acceptance, so output
//   back-pressure only affects it through s_axis_tready.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   s_axis_t*                slave stream (data/keep/valid/ready/last)
//   m_axis_t*                master stream (data/keep/valid/ready/last)
//   len_value / len_err      length and error flag of the last completed frame
//   len_valid                1-cycle strobe when len_value/len_err update
//   stat_clear               synchronous clear of frame_count/byte_count
//   frame_count/byte_count   frames/bytes accepted since reset or clear (wrap)
// ---------------------------------------------------------------------------
module axis_frame_meter #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [LEN_WIDTH-1:0]  len_value,
    output logic                  len_valid,
    output logic                  len_err,
    input  logic                  stat_clear,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  byte_count
);

    localparam int BCNT_W = $clog2(KEEP_WIDTH + 1);

    typedef enum logic {
        IDLE,
        IN_FRAME
    } state_t;

    // ------------------------------------------------------------------
    // Skid buffer: main register drives m_axis, spare catches the beat
    // accepted while main is stalled. tready is registered and equals
    // "spare empty" for the next cycle.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic [KEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
    logic                  m_tlast_q, m_tlast_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic [DATA_WIDTH-1:0] sp_tdata_q, sp_tdata_d;
    logic [KEEP_WIDTH-1:0] sp_tkeep_q, sp_tkeep_d;
    logic                  sp_tlast_q, sp_tlast_d;
    logic                  sp_valid_q, sp_valid_d;
    logic                  s_tready_q, s_tready_d;

    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q;
        sp_tdata_d = sp_tdata_q;
        sp_tkeep_d = sp_tkeep_q;
        sp_tlast_d = sp_tlast_q;
        sp_valid_d = sp_valid_q;
        if (s_tready_q) begin
            if (m_axis_tready || !m_tvalid_q) begin
                // Main is free (or draining this cycle): input goes straight in.
                m_tvalid_d = s_axis_tvalid;
                if (s_axis_tvalid) begin
                    m_tdata_d = s_axis_tdata;
                    m_tkeep_d = s_axis_tkeep;
                    m_tlast_d = s_axis_tlast;
                end
            end else if (s_axis_tvalid) begin
                // Main is stalled: park the beat in the spare.
                sp_tdata_d = s_axis_tdata;
                sp_tkeep_d = s_axis_tkeep;
                sp_tlast_d = s_axis_tlast;
                sp_valid_d = 1'b1;
            end
        end else if (m_axis_tready) begin
            // Input blocked; move the spare forward as main drains.
            m_tvalid_d = sp_valid_q;
            if (sp_valid_q) begin
                m_tdata_d = sp_tdata_q;
                m_tkeep_d = sp_tkeep_q;
                m_tlast_d = sp_tlast_q;
            end
            sp_valid_d = 1'b0;
        end
        s_tready_d = !sp_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
            sp_tdata_q <= '0;
            sp_tkeep_q <= '0;
            sp_tlast_q <= 1'b0;
            sp_valid_q <= 1'b0;
            s_tready_q <= 1'b0;
        end else begin
            m_tdata_q  <= m_tdata_d;
            m_tkeep_q  <= m_tkeep_d;
            m_tlast_q  <= m_tlast_d;
            m_tvalid_q <= m_tvalid_d;
            sp_tdata_q <= sp_tdata_d;
            sp_tkeep_q <= sp_tkeep_d;
            sp_tlast_q <= sp_tlast_d;
            sp_valid_q <= sp_valid_d;
            s_tready_q <= s_tready_d;
        end
    end

    // ------------------------------------------------------------------
    // Beat analysis
    // ------------------------------------------------------------------
    logic                  beat_acc;
    logic [BCNT_W-1:0]     beat_bytes;
    logic [KEEP_WIDTH-1:0] keep_inc;
    logic                  keep_contig;
    logic                  beat_bad;

    assign beat_acc = s_axis_tvalid && s_tready_q;

    always_comb begin
        beat_bytes = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            beat_bytes = beat_bytes + BCNT_W'(s_axis_tkeep[i]);
        end
    end

    // A mask is contiguous from bit 0 exactly when adding one clears every
    // set bit (all-ones wraps to zero and also qualifies).
    assign keep_inc    = s_axis_tkeep + KEEP_WIDTH'(1);
    assign keep_contig = ((s_axis_tkeep & keep_inc) == '0);
    assign beat_bad    = (s_axis_tkeep == '0) ||
                         (s_axis_tlast ? !keep_contig : (s_axis_tkeep != '1));

    // ------------------------------------------------------------------
    // Frame FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (beat_acc) begin
            state_d = s_axis_tlast ? IDLE : IN_FRAME;
        end
    end

    logic [LEN_WIDTH-1:0] acc_q, acc_d;
    logic                 ferr_q, ferr_d;
    logic [LEN_WIDTH-1:0] acc_base;
    logic                 err_base;

    // A beat seen in IDLE opens a new frame, so it starts from a clean base.
    always_comb begin
        acc_base = '0;
        err_base = 1'b0;
        if (state_q == IN_FRAME) begin
            acc_base = acc_q;
            err_base = ferr_q;
        end
    end

    // ------------------------------------------------------------------
    // Length accumulation with saturation
    // ------------------------------------------------------------------
    logic [LEN_WIDTH:0]   sum;
    logic                 sat;
    logic [LEN_WIDTH-1:0] len_next;
    logic                 err_next;

    assign sum      = {1'b0, acc_base} + (LEN_WIDTH + 1)'(beat_bytes);
    assign sat      = sum[LEN_WIDTH];
    assign len_next = sat ? '1 : sum[LEN_WIDTH-1:0];
    assign err_next = err_base || beat_bad || sat;

    logic [LEN_WIDTH-1:0] len_value_q, len_value_d;
    logic                 len_valid_q, len_valid_d;
    logic                 len_err_q, len_err_d;

    always_comb begin
        acc_d       = acc_q;
        ferr_d      = ferr_q;
        len_value_d = len_value_q;
        len_err_d   = len_err_q;
        len_valid_d = 1'b0;
        if (beat_acc) begin
            if (s_axis_tlast) begin
                acc_d       = '0;
                ferr_d      = 1'b0;
                len_value_d = len_next;
                len_err_d   = err_next;
                len_valid_d = 1'b1;
            end else begin
                acc_d  = len_next;
                ferr_d = err_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics (clear wins over a same-cycle beat)
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        if (stat_clear) begin
            frame_cnt_d = '0;
            byte_cnt_d  = '0;
        end else if (beat_acc) begin
            byte_cnt_d = byte_cnt_q + CNT_WIDTH'(beat_bytes);
            if (s_axis_tlast) begin
                frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            ferr_q      <= 1'b0;
            len_value_q <= '0;
            len_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
            frame_cnt_q <= '0;
            byte_cnt_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            ferr_q      <= ferr_d;
            len_value_q <= len_value_d;
            len_valid_q <= len_valid_d;
            len_err_q   <= len_err_d;
            frame_cnt_q <= frame_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign s_axis_tready = s_tready_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign len_value     = len_value_q;
    assign len_valid     = len_valid_q;
    assign len_err       = len_err_q;
    assign frame_count   = frame_cnt_q;
    assign byte_count    = byte_cnt_q;

endmodule

// File: tb/tb_axis_frame_meter.sv
// ---------------------------------------------------------------------------
// tb_axis_frame_meter
//   Drives two axis_frame_meter instances (LEN_WIDTH 16 and 8) from the same
//   stimulus and checks them against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_axis_frame_meter;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] s_tdata  = '0;
    logic [KW-1:0] s_tkeep  = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast  = 1'b0;
    logic          m_tready = 1'b0;
    logic          stat_clear = 1'b0;

    logic          s_tready, m_tvalid, m_tlast, len_valid, len_err;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [15:0]   len_value;
    logic [CW-1:0] frame_count, byte_count;

    logic          s_tready8, m_tvalid8, m_tlast8, len_valid8, len_err8;
    logic [DW-1:0] m_tdata8;
    logic [KW-1:0] m_tkeep8;
    logic [7:0]    len_value8;
    logic [CW-1:0] frame_count8, byte_count8;

    axis_frame_meter #(.DATA_WIDTH(DW), .LEN_WIDTH(16), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .len_value(len_value), .len_valid(len_valid), .len_err(len_err),
        .stat_clear(stat_clear), .frame_count(frame_count), .byte_count(byte_count)
    );

    axis_frame_meter #(.DATA_WIDTH(DW), .LEN_WIDTH(8), .CNT_WIDTH(CW)) dut8 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready8), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata8), .m_axis_tkeep(m_tkeep8), .m_axis_tvalid(m_tvalid8),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast8),
        .len_value(len_value8), .len_valid(len_valid8), .len_err(len_err8),
        .stat_clear(stat_clear), .frame_count(frame_count8), .byte_count(byte_count8)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // 0: hold m_tready low, 1: hold high, 2: random 50%
    int ready_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 2)      m_tready = 1'($urandom_range(0, 1));
            else if (ready_mode == 1) m_tready = 1'b1;
            else                      m_tready = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Reference model (frame level) and observation capture
    // ------------------------------------------------------------------
    function automatic int popcnt(input logic [KW-1:0] k);
        int c = 0;
        for (int i = 0; i < KW; i++) if (k[i]) c++;
        return c;
    endfunction

    function automatic bit keep_ok(input logic [KW-1:0] k, input logic last);
        bit seen_zero = 0;
        int c = popcnt(k);
        if (c == 0) return 0;
        for (int i = 0; i < KW; i++) begin
            if (!k[i]) seen_zero = 1;
            else if (seen_zero) return 0;
        end
        return last ? 1'b1 : (c == KW);
    endfunction

    logic [DW+KW:0] exp_beats[$];
    logic [DW+KW:0] out_beats[$];
    logic [16:0]    exp_len16[$];
    logic [16:0]    obs_len16[$];
    logic [8:0]     exp_len8[$];
    logic [8:0]     obs_len8[$];
    int unsigned    mdl_bytes;
    bit             mdl_bad;
    logic [CW-1:0]  mdl_frames, mdl_bytecnt;
    bit             prev_hold = 0;
    logic [DW+KW:0] prev_beat;
    int             stab_viol = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_beats.delete(); out_beats.delete();
            exp_len16.delete(); obs_len16.delete();
            exp_len8.delete();  obs_len8.delete();
            mdl_bytes = 0; mdl_bad = 0; mdl_frames = '0; mdl_bytecnt = '0;
            prev_hold = 0;
        end else begin
            if (prev_hold && ({m_tlast, m_tkeep, m_tdata} !== prev_beat)) stab_viol++;
            prev_hold = m_tvalid && !m_tready;
            prev_beat = {m_tlast, m_tkeep, m_tdata};
            if (m_tvalid && m_tready) out_beats.push_back({m_tlast, m_tkeep, m_tdata});
            if (len_valid)  obs_len16.push_back({len_err, len_value});
            if (len_valid8) obs_len8.push_back({len_err8, len_value8});
            if (s_tvalid && s_tready) begin
                exp_beats.push_back({s_tlast, s_tkeep, s_tdata});
                mdl_bytes += popcnt(s_tkeep);
                if (!keep_ok(s_tkeep, s_tlast)) mdl_bad = 1;
                mdl_bytecnt += CW'(popcnt(s_tkeep));
                if (s_tlast) begin
                    exp_len16.push_back({mdl_bad || mdl_bytes > 65535,
                                         16'(mdl_bytes > 65535 ? 65535 : mdl_bytes)});
                    exp_len8.push_back({mdl_bad || mdl_bytes > 255,
                                        8'(mdl_bytes > 255 ? 255 : mdl_bytes)});
                    mdl_frames += 1;
                    mdl_bytes = 0;
                    mdl_bad = 0;
                end
            end
            if (stat_clear) begin
                mdl_frames = '0;
                mdl_bytecnt = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; stat_clear = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        bit acc = 0;
        int n = 0;
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
            n++;
        end
        s_tvalid = 1'b0;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_beat_timeout: tready=%b required 1 within 200 cycles", s_tready);
        end
    endtask

    task automatic drain();
        ready_mode = 1;
        repeat (6) @(posedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        ready_mode = 1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_stream: got %0h required 0", {s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata});
        end
        n_cmp++;
        if ({len_valid, len_err, len_value, frame_count, byte_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_meter: got %0h required 0", {len_valid, len_err, len_value, frame_count, byte_count});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after: got %b required 1", s_tready);
        end
    endtask

    task automatic test_basic_frame();
        logic [DW-1:0] d[3];
        logic [KW-1:0] k[3];
        ready_mode = 1;
        do_reset();
        k[0] = 8'hFF; k[1] = 8'hFF; k[2] = 8'h0F;
        for (int i = 0; i < 3; i++) d[i] = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1; s_tdata = d[i]; s_tkeep = k[i]; s_tlast = (i == 2);
            @(negedge clk);
            n_cmp++;
            if (s_tready !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_ready beat %0d: got %b required 1", i, s_tready);
            end
            if (i > 0) begin
                n_cmp++;
                if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== {1'b1, 1'b0, k[i-1], d[i-1]}) begin
                    n_fail++;
                    $display("FAIL basic_out beat %0d: got %0h required %0h", i - 1,
                             {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, 1'b0, k[i-1], d[i-1]});
                end
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== {1'b1, 1'b1, k[2], d[2]}) begin
            n_fail++;
            $display("FAIL basic_out_last: got %0h required %0h",
                     {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, 1'b1, k[2], d[2]});
        end
        n_cmp++;
        if ({len_valid, len_err, len_value} !== {1'b1, 1'b0, 16'd20}) begin
            n_fail++;
            $display("FAIL basic_len: got v=%b e=%b len=%0d required v=1 e=0 len=20", len_valid, len_err, len_value);
        end
        n_cmp++;
        if (frame_count !== 32'd1 || byte_count !== 32'd20) begin
            n_fail++;
            $display("FAIL basic_counts: got %0d/%0d required 1/20", frame_count, byte_count);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({len_valid, m_tvalid, len_value} !== {1'b0, 1'b0, 16'd20}) begin
            n_fail++;
            $display("FAIL basic_after: got v=%b mv=%b len=%0d required v=0 mv=0 len=20", len_valid, m_tvalid, len_value);
        end
    endtask

    task automatic test_back_to_back();
        ready_mode = 2;
        do_reset();
        for (int i = 0; i < 100; i++) send_beat({$urandom, $urandom}, 8'hFF, 1'b1);
        drain();
        n_cmp++;
        if (out_beats.size() != 100 || exp_beats.size() != 100) begin
            n_fail++;
            $display("FAIL b2b_beat_count: got out=%0d in=%0d required 100", out_beats.size(), exp_beats.size());
        end
        for (int i = 0; i < out_beats.size() && i < exp_beats.size(); i++) begin
            n_cmp++;
            if (out_beats[i] !== exp_beats[i]) begin
                n_fail++;
                $display("FAIL b2b_beat %0d: got %0h required %0h", i, out_beats[i], exp_beats[i]);
            end
        end
        n_cmp++;
        if (obs_len16.size() != 100) begin
            n_fail++;
            $display("FAIL b2b_len_count: got %0d required 100", obs_len16.size());
        end
        for (int i = 0; i < obs_len16.size(); i++) begin
            n_cmp++;
            if (obs_len16[i] !== {1'b0, 16'd8}) begin
                n_fail++;
                $display("FAIL b2b_len %0d: got %0h required %0h", i, obs_len16[i], {1'b0, 16'd8});
            end
        end
        n_cmp++;
        if (frame_count !== 32'd100 || byte_count !== 32'd800) begin
            n_fail++;
            $display("FAIL b2b_counts: got %0d/%0d required 100/800", frame_count, byte_count);
        end
    endtask

    task automatic test_malformed();
        logic [16:0] req[3];
        ready_mode = 1;
        do_reset();
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        send_beat({$urandom, $urandom}, 8'h0F, 1'b0);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b1);
        send_beat({$urandom, $urandom}, 8'h05, 1'b1);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        send_beat({$urandom, $urandom}, 8'h03, 1'b1);
        drain();
        req[0] = {1'b1, 16'd20}; req[1] = {1'b1, 16'd2}; req[2] = {1'b0, 16'd10};
        n_cmp++;
        if (obs_len16.size() != 3) begin
            n_fail++;
            $display("FAIL malformed_count: got %0d required 3", obs_len16.size());
        end
        for (int i = 0; i < 3 && i < obs_len16.size(); i++) begin
            n_cmp++;
            if (obs_len16[i] !== req[i]) begin
                n_fail++;
                $display("FAIL malformed_len %0d: got %0h required %0h", i, obs_len16[i], req[i]);
            end
        end
    endtask

    task automatic test_saturation();
        ready_mode = 1;
        do_reset();
        for (int i = 0; i < 40; i++) send_beat({$urandom, $urandom}, 8'hFF, i == 39);
        drain();
        n_cmp++;
        if (obs_len8.size() != 1 || obs_len8[0] !== {1'b1, 8'd255}) begin
            n_fail++;
            $display("FAIL sat_len8: got n=%0d v=%0h required n=1 v=%0h", obs_len8.size(),
                     obs_len8.size() ? obs_len8[0] : 9'h0, {1'b1, 8'd255});
        end
        n_cmp++;
        if (obs_len16.size() != 1 || obs_len16[0] !== {1'b0, 16'd320}) begin
            n_fail++;
            $display("FAIL sat_len16: got n=%0d v=%0h required n=1 v=%0h", obs_len16.size(),
                     obs_len16.size() ? obs_len16[0] : 17'h0, {1'b0, 16'd320});
        end
        n_cmp++;
        if (byte_count8 !== 32'd320 || byte_count !== 32'd320) begin
            n_fail++;
            $display("FAIL sat_bytes: got %0d/%0d required 320", byte_count8, byte_count);
        end
    endtask

    task automatic test_stat_clear();
        ready_mode = 1;
        do_reset();
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        stat_clear = 1'b1;
        send_beat({$urandom, $urandom}, 8'hFF, 1'b1);
        stat_clear = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (frame_count !== '0 || byte_count !== '0) begin
            n_fail++;
            $display("FAIL clear_counts: got %0d/%0d required 0/0", frame_count, byte_count);
        end
        n_cmp++;
        if ({len_valid, len_err, len_value} !== {1'b1, 1'b0, 16'd16}) begin
            n_fail++;
            $display("FAIL clear_len: got v=%b e=%b len=%0d required v=1 e=0 len=16", len_valid, len_err, len_value);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midframe();
        ready_mode = 0;
        do_reset();
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        s_tvalid = 1'b1; s_tdata = {$urandom, $urandom}; s_tkeep = 8'hFF; s_tlast = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({s_tready, m_tvalid} !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_full: got ready=%b valid=%b required ready=0 valid=1", s_tready, m_tvalid);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({m_tvalid, s_tready, len_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_async: got mv=%b rdy=%b lv=%b required 000", m_tvalid, s_tready, len_valid);
        end
        s_tvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (len_valid !== 1'b0 || m_tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_hold %0d: got lv=%b mv=%b required 0", i, len_valid, m_tvalid);
            end
        end
        rst = 1'b0;
        ready_mode = 1;
        @(posedge clk);
        #1;
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        send_beat({$urandom, $urandom}, 8'h03, 1'b1);
        drain();
        n_cmp++;
        if (obs_len16.size() != 1 || obs_len16[0] !== {1'b0, 16'd10}) begin
            n_fail++;
            $display("FAIL midrst_len: got n=%0d v=%0h required n=1 v=%0h", obs_len16.size(),
                     obs_len16.size() ? obs_len16[0] : 17'h0, {1'b0, 16'd10});
        end
        n_cmp++;
        if (frame_count !== 32'd1 || byte_count !== 32'd10) begin
            n_fail++;
            $display("FAIL midrst_counts: got %0d/%0d required 1/10", frame_count, byte_count);
        end
        n_cmp++;
        if (out_beats.size() != 2 || out_beats[0] !== exp_beats[0] || out_beats[1] !== exp_beats[1]) begin
            n_fail++;
            $display("FAIL midrst_beats: got n=%0d required 2 matching accepted beats", out_beats.size());
        end
    endtask

    task automatic test_random_frames();
        logic [KW-1:0] k;
        int nb, n;
        ready_mode = 2;
        do_reset();
        for (int f = 0; f < 40; f++) begin
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 9) == 0) begin
                    k = 8'($urandom_range(0, 255));
                end else if (b == nb - 1) begin
                    n = $urandom_range(1, 8);
                    k = 8'((16'h1 << n) - 16'h1);
                end else begin
                    k = 8'hFF;
                end
                stat_clear = (f == 20 && b == 0);
                send_beat({$urandom, $urandom}, k, b == nb - 1);
                stat_clear = 1'b0;
            end
        end
        drain();
        n_cmp++;
        if (out_beats.size() != exp_beats.size()) begin
            n_fail++;
            $display("FAIL rand_beat_count: got %0d required %0d", out_beats.size(), exp_beats.size());
        end
        for (int i = 0; i < out_beats.size() && i < exp_beats.size(); i++) begin
            n_cmp++;
            if (out_beats[i] !== exp_beats[i]) begin
                n_fail++;
                $display("FAIL rand_beat %0d: got %0h required %0h", i, out_beats[i], exp_beats[i]);
            end
        end
        n_cmp++;
        if (obs_len16.size() != 40 || obs_len8.size() != 40) begin
            n_fail++;
            $display("FAIL rand_len_count: got %0d/%0d required 40", obs_len16.size(), obs_len8.size());
        end
        for (int i = 0; i < obs_len16.size() && i < exp_len16.size(); i++) begin
            n_cmp++;
            if (obs_len16[i] !== exp_len16[i] || obs_len8[i] !== exp_len8[i]) begin
                n_fail++;
                $display("FAIL rand_len %0d: got %0h/%0h required %0h/%0h", i,
                         obs_len16[i], obs_len8[i], exp_len16[i], exp_len8[i]);
            end
        end
        n_cmp++;
        if (frame_count !== mdl_frames || byte_count !== mdl_bytecnt) begin
            n_fail++;
            $display("FAIL rand_counts: got %0d/%0d required %0d/%0d", frame_count, byte_count, mdl_frames, mdl_bytecnt);
        end
    endtask

    task automatic test_stability();
        n_cmp++;
        if (stab_viol != 0) begin
            n_fail++;
            $display("FAIL stall_stability: got %0d changes while stalled required 0", stab_viol);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_malformed();
        test_saturation();
        test_stat_clear();
        test_reset_midframe();
        test_random_frames();
        test_stability();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
